dpsram_fifo_ctrl: RTL

Streaming FIFO controller wrapped around the 256x4 dual-port SRAM macro (TSDN28HPCA256X4M8FW). It converts a valid/ready write stream into port-A write cycles and produces a valid/ready read stream from port-B reads. It hides the macro's one-cycle read latency with a 2-entry output buffer, so sustained throughput is 1 word/cycle. It sits directly upstream of the macro and owns all of its A/B control pins. WTSEL/RTSEL/VG/VS are tied at the top level.

---
 rtl/dpsram_fifo_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/dpsram_fifo_ctrl.sv
// Streaming FIFO controller for a 256x4 dual-port SRAM macro: port A writes, port B reads into a 2-entry output buffer.
// Latency: a word accepted at edge t is read at t+1, captured at t+2, and shows out_valid after t+2; 1 word/cycle sustained.
// Backpressure: in_ready drops when the SRAM holds W words; reads stall while the buffer plus the in-flight read would exceed 2.
module dpsram_fifo_ctrl #(
    parameter int N = 4,
    parameter int M = 8,
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [M:0]   level,
    output logic [M-1:0] AA,
    output logic [N-1:0] DA,
    output logic [N-1:0] BWEBA,
    output logic         WEBA,
    output logic         CEBA,
    output logic [M-1:0] AB,
    output logic [N-1:0] DB,
    output logic [N-1:0] BWEBB,
    output logic         WEBB,
    output logic         CEBB,
    input  logic [N-1:0] QB
);

    localparam logic [M:0] DEPTH = (M+1)'(W);

    logic [M-1:0] wr_ptr, rd_ptr;
    logic [M:0]   sram_cnt;
    logic         rd_pend;
    logic [1:0]   ob_cnt;
    logic [N-1:0] ob0, ob1;
    logic         wr_en, pop, rd_issue;
    logic [2:0]   occ;

    assign in_ready  = ~rst & (sram_cnt != DEPTH);
    assign wr_en     = in_valid & in_ready;
    assign out_valid = (ob_cnt != 2'd0);
    assign out_data  = ob0;
    assign pop       = out_valid & out_ready;

    // Buffer slots already spoken for; a pop this cycle frees one for a new read.
    assign occ      = {1'b0, ob_cnt} + {2'b00, rd_pend};
    assign rd_issue = (sram_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));

    assign level = sram_cnt + (M+1)'(rd_pend) + (M+1)'(ob_cnt);

    assign AA    = wr_ptr;
    assign DA    = in_data;
    assign BWEBA = '0;
    assign WEBA  = ~wr_en;
    assign CEBA  = ~wr_en;
    assign AB    = rd_ptr;
    assign DB    = '0;
    assign BWEBB = '1;
    assign WEBB  = 1'b1;
    assign CEBB  = ~rd_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            rd_pend  <= 1'b0;
            ob_cnt   <= 2'd0;
            ob0      <= '0;
            ob1      <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + M'(1);
            if (rd_issue)
                rd_ptr <= rd_ptr + M'(1);
            case ({wr_en, rd_issue})
                2'b10:   sram_cnt <= sram_cnt + (M+1)'(1);
                2'b01:   sram_cnt <= sram_cnt - (M+1)'(1);
                default: sram_cnt <= sram_cnt;
            endcase
            rd_pend <= rd_issue;

            // QB lands behind whatever survives this cycle's pop, keeping order.
            if (rd_pend && pop) begin
                if (ob_cnt == 2'd2) begin
                    ob0 <= ob1;
                    ob1 <= QB;
                end else begin
                    ob0 <= QB;
                end
            end else if (pop) begin
                ob0    <= ob1;
                ob_cnt <= ob_cnt - 2'd1;
            end else if (rd_pend) begin
                if (ob_cnt == 2'd0)
                    ob0 <= QB;
                else
                    ob1 <= QB;
                ob_cnt <= ob_cnt + 2'd1;
            end
        end
    end

endmodule
